// File: rtl/score_topk_sorter_pkg.sv
// Shared definitions for the top-K score sorter: float16 field layout,
// default list geometry and the controller state encoding.
package score_topk_sorter_pkg;

    localparam int FP16_W   = 16;
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_MSB  = 9;
    localparam int MAN_LSB  = 0;

    localparam int DEF_K    = 16;
    localparam int DEF_ID_W = 10;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/score_topk_sorter_fp16_gt.sv
// fp16_gt: combinational strict a > b on float16 bit patterns.
// Order is sign first, then exponent, then mantissa. A positive value beats
// any negative one (so +0 > -0); among negatives the larger magnitude is the
// smaller value. NaN/Inf get no special treatment.
module fp16_gt
    import score_topk_sorter_pkg::*;
(
    input  logic [FP16_W-1:0] a_i,
    input  logic [FP16_W-1:0] b_i,
    output logic              gt_o
);

    logic                   sign_a, sign_b;
    logic [EXP_MSB-EXP_LSB:0] exp_a, exp_b;
    logic [MAN_MSB-MAN_LSB:0] man_a, man_b;
    logic                   mag_gt, mag_lt;

    // Field split and magnitude compare: exponent decides, mantissa breaks ties.
    always_comb begin
        sign_a = a_i[SIGN_BIT];
        sign_b = b_i[SIGN_BIT];
        exp_a  = a_i[EXP_MSB:EXP_LSB];
        exp_b  = b_i[EXP_MSB:EXP_LSB];
        man_a  = a_i[MAN_MSB:MAN_LSB];
        man_b  = b_i[MAN_MSB:MAN_LSB];
        mag_gt = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a > man_b));
        mag_lt = (exp_a < exp_b) || ((exp_a == exp_b) && (man_a < man_b));
        if (sign_a != sign_b) begin
            gt_o = sign_b;
        end else if (!sign_a) begin
            gt_o = mag_gt;
        end else begin
            gt_o = mag_lt;
        end
    end

endmodule

// File: rtl/score_topk_sorter.sv
// score_topk_sorter: streaming top-K collector. Candidates are inserted into
// a descending-sorted slot array (stable on ties); after the in_last beat the
// list drains highest score first.
// Optional feature macro: SCORE_THRESH_EN adds the thresh port and drops
// candidates scoring below it.
module score_topk_sorter
    import score_topk_sorter_pkg::*;
#(
    parameter int K    = DEF_K,
    parameter int ID_W = DEF_ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_score,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_last,
`ifdef SCORE_THRESH_EN
    input  logic [FP16_W-1:0] thresh,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] out_score,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              done
);

    localparam int CNT_W = $clog2(K + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FP16_W-1:0] score_q [K];
    logic [FP16_W-1:0] score_d [K];
    logic [ID_W-1:0]   id_q    [K];
    logic [ID_W-1:0]   id_d    [K];
    logic              done_q, done_d;
    logic [K-1:0]      gt_raw;
    logic [K-1:0]      gt;
    logic              keep;
    int                pos;

    // One comparator per slot; only occupied slots may claim the insert point.
    for (genvar g = 0; g < K; g++) begin : g_cmp
        fp16_gt u_gt (
            .a_i  (in_score),
            .b_i  (score_q[g]),
            .gt_o (gt_raw[g])
        );
        assign gt[g] = gt_raw[g] && (CNT_W'(g) < count_q);
    end

`ifdef SCORE_THRESH_EN
    logic below_thresh;

    fp16_gt u_thresh_gt (
        .a_i  (thresh),
        .b_i  (in_score),
        .gt_o (below_thresh)
    );
    assign keep = !below_thresh;
`else
    assign keep = 1'b1;
`endif

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN) && (count_q != '0);
    assign out_last  = (state_q == ST_DRAIN) && (count_q == CNT_W'(1));
    assign out_score = score_q[0];
    assign out_id    = id_q[0];
    assign done      = done_q;

    // Next-state: sorted insertion in LOAD, shift-up drain in DRAIN.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        score_d = score_q;
        id_d    = id_q;
        done_d  = 1'b0;
        // First slot strictly below the new score; ties fall through so the sort stays stable.
        // NOTE: blocking assignments here -- later statements read the values just computed.
        pos = int'(count_q);
        for (int i = K - 1; i >= 0; i--) begin
            if (gt[i]) pos = i;
        end

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (keep && (pos < K)) begin
                        for (int i = 0; i < K; i++) begin
                            if (i == pos) begin
                                score_d[i] = in_score;
                                id_d[i]    = in_id;
                            end else if (i > pos) begin
                                score_d[i] = score_q[i-1];
                                id_d[i]    = id_q[i-1];
                            end
                        end
                        if (count_q != CNT_W'(K)) count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        if (count_d == '0) done_d  = 1'b1;
                        else               state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    for (int i = 0; i < K - 1; i++) begin
                        score_d[i] = score_q[i+1];
                        id_d[i]    = id_q[i+1];
                    end
                    score_d[K-1] = '0;
                    id_d[K-1]    = '0;
                    count_d      = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_LOAD;
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State, count, slot array and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            done_q  <= 1'b0;
            // NOTE: the slot array is reset explicitly because slot 0 drives out_score/out_id.
            for (int i = 0; i < K; i++) begin
                score_q[i] <= '0;
                id_q[i]    <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            score_q <= score_d;
            id_q    <= id_d;
        end
    end

endmodule
